// File: rtl/coderam_pkg.sv
// Shared constants and encodings for the code-RAM arbiter.
package coderam_pkg;

  localparam int AW = 13;
  localparam int DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_e;

endpackage

// File: rtl/coderam_arbiter_if.sv
// Requester-side bus for the code-RAM arbiter: CPU port and loader/debug port.
// master = requesters, slave = arbiter.
interface coderam_arbiter_if
  import coderam_pkg::*;
#(
  parameter int AW = coderam_pkg::AW,
  parameter int DW = coderam_pkg::DW
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ack;
  logic [DW-1:0] ld_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_ack, ld_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_ack, ld_rdata
  );
endinterface

// File: rtl/coderam_arb_pick.sv
// Combinational grant selector. CPU has fixed priority; with
// CODERAM_ARB_FAIRNESS_EN defined the loader is forced through once the
// starve count reaches STARVE_MAX.
module coderam_arb_pick
  import coderam_pkg::*;
`ifdef CODERAM_ARB_FAIRNESS_EN
#(
  parameter int STARVE_MAX = 4,
  parameter int SCW        = $clog2(STARVE_MAX + 1)
)
`endif
(
  input  logic           cpu_req,
  input  logic           ld_req,
`ifdef CODERAM_ARB_FAIRNESS_EN
  input  logic [SCW-1:0] starve_cnt,
`endif
  output owner_e         winner
);

  // Winner select; with no request at all the answer is CPU and is unused.
  always_comb begin
    winner = OWN_CPU;
`ifdef CODERAM_ARB_FAIRNESS_EN
    if (ld_req && (!cpu_req || (starve_cnt == SCW'(STARVE_MAX))))
      winner = OWN_LD;
`else
    if (ld_req && !cpu_req)
      winner = OWN_LD;
`endif
  end

endmodule

// File: rtl/coderam_arbiter.sv
// Two-port arbiter/sequencer for the 8K x 8 synchronous code SRAM.
// All RAM pins are registered; every transaction is IDLE->ACCESS->CAPTURE->ACK.
// Optional loader fairness: define CODERAM_ARB_FAIRNESS_EN.
//
// state   | meaning
// IDLE    | arbitrate; load RAM pins and owner on a request
// ACCESS  | RAM pins stable, RAM performs the access at the next edge
// CAPTURE | ram_out valid; load owner rdata (reads), raise owner ack
// ACK     | owner ack high for one cycle; no arbitration here
module coderam_arbiter
  import coderam_pkg::*;
#(
`ifdef CODERAM_ARB_FAIRNESS_EN
  parameter int STARVE_MAX = 4,
`endif
  parameter int AW = coderam_pkg::AW,
  parameter int DW = coderam_pkg::DW
)(
  input  logic             clk,
  input  logic             reset_n,
  coderam_arbiter_if.slave bus,
  output logic [AW-1:0]    ram_a,
  output logic [DW-1:0]    ram_in,
  output logic             ram_cs_n,
  output logic             ram_we_n,
  input  logic [DW-1:0]    ram_out,
  output logic             busy
);

`ifdef CODERAM_ARB_FAIRNESS_EN
  localparam int SCW = $clog2(STARVE_MAX + 1);
  logic [SCW-1:0] starve_q, starve_d;
`endif

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] ram_a_q, ram_a_d;
  logic [DW-1:0] ram_in_q, ram_in_d;
  logic          cs_n_q, cs_n_d;
  logic          we_n_q, we_n_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          ld_ack_q, ld_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] ld_rdata_q, ld_rdata_d;

  owner_e        pick;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  coderam_arb_pick
`ifdef CODERAM_ARB_FAIRNESS_EN
  #(.STARVE_MAX(STARVE_MAX))
`endif
  u_pick (
    .cpu_req    (bus.cpu_req),
    .ld_req     (bus.ld_req),
`ifdef CODERAM_ARB_FAIRNESS_EN
    .starve_cnt (starve_q),
`endif
    .winner     (pick)
  );

  // Mux the winning port's request fields.
  always_comb begin
    sel_we    = bus.cpu_we;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    if (pick == OWN_LD) begin
      sel_we    = bus.ld_we;
      sel_addr  = bus.ld_addr;
      sel_wdata = bus.ld_wdata;
    end
  end

  // State register and all datapath registers; reset aborts any transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      ram_a_q     <= '0;
      ram_in_q    <= '0;
      cs_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      cpu_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
`ifdef CODERAM_ARB_FAIRNESS_EN
      starve_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      ram_a_q     <= ram_a_d;
      ram_in_q    <= ram_in_d;
      cs_n_q      <= cs_n_d;
      we_n_q      <= we_n_d;
      cpu_ack_q   <= cpu_ack_d;
      ld_ack_q    <= ld_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
`ifdef CODERAM_ARB_FAIRNESS_EN
      starve_q    <= starve_d;
`endif
    end
  end

  // Next-state and outputs; strobes default inactive so cs_n lasts one cycle.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    ram_a_d     = ram_a_q;
    ram_in_d    = ram_in_q;
    cs_n_d      = 1'b1;
    we_n_d      = 1'b1;
    cpu_ack_d   = 1'b0;
    ld_ack_d    = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
`ifdef CODERAM_ARB_FAIRNESS_EN
    starve_d    = starve_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req || bus.ld_req) begin
          owner_d  = pick;
          we_d     = sel_we;
          ram_a_d  = sel_addr;
          ram_in_d = sel_wdata;
          cs_n_d   = 1'b0;
          we_n_d   = ~sel_we;
          state_d  = ST_ACCESS;
        end
`ifdef CODERAM_ARB_FAIRNESS_EN
        // Count CPU wins over a waiting loader; reaching STARVE_MAX forces
        // a loader win, which clears the count, so it never overflows.
        if (!bus.ld_req || pick == OWN_LD)
          starve_d = '0;
        else
          starve_d = starve_q + 1'b1;
`endif
      end
      ST_ACCESS: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (owner_q == OWN_CPU) begin
          cpu_ack_d = 1'b1;
          if (!we_q) cpu_rdata_d = ram_out;
        end else begin
          ld_ack_d = 1'b1;
          if (!we_q) ld_rdata_d = ram_out;
        end
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ram_a         = ram_a_q;
  assign ram_in        = ram_in_q;
  assign ram_cs_n      = cs_n_q;
  assign ram_we_n      = we_n_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.ld_ack    = ld_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ld_rdata  = ld_rdata_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_coderam_arbiter.sv
// Bench for coderam_arbiter: behavioural SRAM, directed vector table,
// hand-written corner sequences and randomized traffic against a reference
// memory model. Define CODERAM_ARB_FAIRNESS_EN to exercise the fair build.
module tb_coderam_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] ram_a;
  logic [7:0]  ram_in;
  logic        ram_cs_n, ram_we_n;
  logic [7:0]  ram_out = 8'h00;
  logic        busy;

  coderam_arbiter_if bus ();

  coderam_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .ram_a    (ram_a),
    .ram_in   (ram_in),
    .ram_cs_n (ram_cs_n),
    .ram_we_n (ram_we_n),
    .ram_out  (ram_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: 1-cycle registered read, active-low cs/we.
  logic [7:0] mem [8192];
  always @(posedge clk) begin
    if (!ram_cs_n) begin
      if (!ram_we_n) mem[ram_a] <= ram_in;
      else           ram_out    <= mem[ram_a];
    end
  end

  // Reference model: memory contents after completed writes, per-port rdata.
  logic [7:0] ref_mem [8192];
  logic [7:0] ref_rd  [2];

  // Bus activity counters sampled mid-cycle.
  int cyc = 0, cs_cnt = 0, we_cnt = 0, bad_we = 0, overlap = 0;
  int ack_cnt [2] = '{0, 0};
  always @(negedge clk) begin
    cyc++;
    if (!ram_cs_n) cs_cnt++;
    if (!ram_we_n) we_cnt++;
    if (!ram_we_n && ram_cs_n) bad_we++;
    if (bus.cpu_ack && bus.ld_ack) overlap++;
    if (bus.cpu_ack) ack_cnt[0]++;
    if (bus.ld_ack)  ack_cnt[1]++;
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One transaction on a port: request at the next negedge, hold until ack,
  // drop on ack. lat counts negedges from request to ack (3 from IDLE).
  task automatic txn(input bit port, input bit we, input logic [12:0] a,
                     input logic [7:0] d, output logic [7:0] rd, output int lat);
    @(negedge clk);
    if (port == 1'b0) begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    end else begin
      bus.ld_req = 1'b1; bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = d;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(port ? bus.ld_ack : bus.cpu_ack) && lat < 20);
    rd = port ? bus.ld_rdata : bus.cpu_rdata;
    if (port == 1'b0) bus.cpu_req = 1'b0;
    else              bus.ld_req  = 1'b0;
    if (lat < 20) begin
      if (we) ref_mem[a] = d;
      else    ref_rd[port] = ref_mem[a];
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    check(name, busy, 1'b0);
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [7:0] rd, rd2, exp;
    int lat, lat2, s_cs, s_we, s_ack0, s_ack1, s_ov, n;
    logic [7:0] ack_mask, busy_mask;

    for (int i = 0; i < 8192; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    mem[13'h0123] = 8'h5A; ref_mem[13'h0123] = 8'h5A;
    ref_rd[0] = 8'h00; ref_rd[1] = 8'h00;

    reset_n = 1'b0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ld_req  = 0; bus.ld_we  = 0; bus.ld_addr  = '0; bus.ld_wdata  = '0;

    // port, we, addr, wdata, expected rdata (writes: held previous rdata)
    vecs[0] = '{1'b0, 1'b0, 13'h0123, 8'h00, 8'h5A};
    vecs[1] = '{1'b1, 1'b1, 13'h1FFF, 8'hA5, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 13'h1FFF, 8'h00, 8'hA5};
    vecs[3] = '{1'b1, 1'b0, 13'h0000, 8'h00, 8'h00};
    vecs[4] = '{1'b0, 1'b1, 13'h0000, 8'h3C, 8'hA5};
    vecs[5] = '{1'b1, 1'b0, 13'h0000, 8'h00, 8'h3C};
    vecs[6] = '{1'b0, 1'b0, 13'h0123, 8'h00, 8'h5A};

    repeat (3) @(negedge clk);
    check("rst_cs_n", ram_cs_n, 1'b1);
    check("rst_we_n", ram_we_n, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ram_a", ram_a, 13'h0);
    check("rst_ram_in", ram_in, 8'h0);
    check("rst_acks", {bus.cpu_ack, bus.ld_ack}, 2'b00);
    check("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
    check("rst_ld_rdata", bus.ld_rdata, 8'h00);
    check("rst_busy", busy, 1'b0);

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      s_cs = cs_cnt; s_we = we_cnt; s_ack0 = ack_cnt[0]; s_ack1 = ack_cnt[1];
      txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
      @(negedge clk);
      check($sformatf("vec%0d_lat", i), lat, 3);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_rdata_held", i),
            vecs[i].port ? bus.ld_rdata : bus.cpu_rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_cs_cycles", i), cs_cnt - s_cs, 1);
      check($sformatf("vec%0d_we_cycles", i), we_cnt - s_we, vecs[i].we ? 1 : 0);
      check($sformatf("vec%0d_own_acks", i),
            vecs[i].port ? ack_cnt[1] - s_ack1 : ack_cnt[0] - s_ack0, 1);
      check($sformatf("vec%0d_other_acks", i),
            vecs[i].port ? ack_cnt[0] - s_ack0 : ack_cnt[1] - s_ack1, 0);
    end

    // Simultaneous requests: CPU first, loader 4 cycles later, no overlap.
    s_ov = overlap;
    fork
      txn(1'b0, 1'b0, 13'h0123, 8'h00, rd, lat);
      txn(1'b1, 1'b0, 13'h1FFF, 8'h00, rd2, lat2);
    join
    @(negedge clk);
    check("simul_cpu_lat", lat, 3);
    check("simul_ld_lat", lat2, 7);
    check("simul_cpu_rdata", rd, 8'h5A);
    check("simul_ld_rdata", rd2, 8'hA5);
    check("simul_overlap", overlap - s_ov, 0);

    // Starvation: CPU held with back-to-back reads while loader waits.
    s_ack0 = ack_cnt[0]; s_ack1 = ack_cnt[1];
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0010;
    bus.ld_req  = 1'b1; bus.ld_we  = 1'b0; bus.ld_addr  = 13'h0123;
    n = 0;
    while (!bus.ld_ack && n < 40) begin @(negedge clk); n++; end
`ifdef CODERAM_ARB_FAIRNESS_EN
    check("starve_ld_lat", n, 19);
    check("starve_cpu_acks", ack_cnt[0] - s_ack0, 4);
    check("starve_ld_rdata", bus.ld_rdata, 8'h5A);
    bus.ld_req = 1'b0; bus.cpu_req = 1'b0;
`else
    check("starve_ld_never", ack_cnt[1] - s_ack1, 0);
    bus.cpu_req = 1'b0;
    n = 0;
    while (!bus.ld_ack && n < 20) begin @(negedge clk); n++; end
    check("starve_ld_after_release", bus.ld_ack, 1'b1);
    check("starve_ld_rdata", bus.ld_rdata, 8'h5A);
    bus.ld_req = 1'b0;
`endif
    wait_idle("starve_idle");
    check("starve_bad_we", bad_we, 0);

    // Held request: one ack per transaction, busy low for the IDLE cycle.
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0123;
    s_ack1 = ack_cnt[1];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ack_mask[i]  = bus.cpu_ack;
      busy_mask[i] = busy;
    end
    bus.cpu_req = 1'b0;
    check("held_ack_pattern", ack_mask, 8'b0100_0100);
    check("held_busy_pattern", busy_mask, 8'b0111_0111);
    check("held_ld_acks", ack_cnt[1] - s_ack1, 0);
    wait_idle("held_idle");

    // Reset during ACCESS of a CPU write: no write, no ack, pins release now.
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0010; bus.cpu_wdata = 8'hEE;
    @(negedge clk);
    check("abort_in_access", {ram_cs_n, ram_we_n}, 2'b00);
    reset_n = 1'b0;
    #1;
    check("abort_cs_n", ram_cs_n, 1'b1);
    check("abort_we_n", ram_we_n, 1'b1);
    check("abort_busy", busy, 1'b0);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    reset_n = 1'b1;
    s_ack0 = ack_cnt[0];
    repeat (6) @(negedge clk);
    check("abort_no_ack", ack_cnt[0] - s_ack0, 0);
    ref_rd[0] = 8'h00; ref_rd[1] = 8'h00;
    txn(1'b0, 1'b0, 13'h0010, 8'h00, rd, lat);
    check("abort_readback", rd, 8'h00);
    check("abort_readback_lat", lat, 3);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      bit          p, w;
      logic [12:0] a;
      logic [7:0]  d;
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 7) ? 13'h1FFF : 13'($urandom_range(0, 6));
      d = 8'($urandom);
      exp = w ? ref_rd[p] : ref_mem[a];
      txn(p, w, a, d, rd, lat);
      check($sformatf("rand%0d_rdata", i), rd, exp);
      check($sformatf("rand%0d_lat", i), lat, 3);
    end
    @(negedge clk);
    check("final_bad_we", bad_we, 0);
    check("final_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/coderam_arbiter.md
Name: coderam_arbiter

Overview:
Two-port arbiter and sequencer for the 8K x 8 synchronous code SRAM. The RAM has a 1-cycle registered read and active-low cs/we.
- Shares the RAM between the CPU bus port (priority) and a loader/debug port, which handles the image load and the shadow-read path.
- Drives every RAM pin from registers and returns read data with a fixed-latency ack.
- Sits between the CPU bus decode and the code RAM instance.

Parameters:
AW, 13, RAM address width (8192 locations)
DW, 8, data width
STARVE_MAX, 4, consecutive CPU grants allowed while the loader waits (used only with the optional feature)

Ports:
clk  in  1  system clock; all state updates on posedge
reset_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU request; held until cpu_ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  CPU read data; valid while cpu_ack=1, held afterwards
ld_req, ld_we, ld_addr, ld_wdata  in  1/1/AW/DW  loader port; same rules as the CPU port
ld_ack, ld_rdata  out  1/DW  loader completion and read data
ram_a  out  AW  RAM address (registered)
ram_in  out  DW  RAM write data (registered)
ram_cs_n  out  1  RAM chip select, active low
ram_we_n  out  1  RAM write enable, active low
ram_out  in  DW  RAM registered read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state IDLE; ram_cs_n=1, ram_we_n=1, ram_a=0, ram_in=0; both acks 0; both rdata 0; grant owner = CPU; starve count 0.
- FSM states: IDLE, ACCESS, CAPTURE, ACK.
- IDLE:
  - If cpu_req and/or ld_req is high at a posedge, arbitrate. Default is fixed priority: CPU wins on simultaneous requests.
  - Latch the owner, ram_a <= addr, ram_in <= wdata, ram_cs_n <= 0, ram_we_n <= ~we. Go to ACCESS.
  - With no request, stay in IDLE with cs_n/we_n high.
- ACCESS (one cycle): RAM pins stable. At the next edge the RAM performs the write or latches the read data.
  - Deassert ram_cs_n and ram_we_n (registered, to 1). Go to CAPTURE.
- CAPTURE (one cycle): ram_out is valid. At the edge, load it into the owner's rdata register (reads only; writes leave rdata unchanged). Raise the owner's ack. Go to ACK.
- ACK (one cycle): owner ack=1, the other ack=0. At the edge, clear ack and go to IDLE.
  - The requester drops req or presents a new request in the cycle after ack.
  - The arbiter never re-arbitrates in ACK, so a held req is not double-served.
- Latency: request sampled at edge N → ack high in the cycle after edge N+2. Reads and writes take the same time. Peak throughput is one access per 4 cycles.
- Exactly one RAM access per transaction. ram_cs_n is low for exactly one cycle. ram_we_n is low only together with ram_cs_n, and only for writes.
- A req arriving during ACCESS/CAPTURE/ACK waits in its requester until IDLE. Requests are never dropped.
- Reset mid-operation: returns immediately to the reset values.
  - A write whose ACCESS edge has not occurred is not performed.
  - No ack is issued for an aborted transaction.
- The non-owner's inputs are ignored for the whole transaction.

Optional Feature:
Macro CODERAM_ARB_FAIRNESS_EN.
- Defined: starve_cnt (width clog2(STARVE_MAX+1)) increments on each CPU grant made while ld_req=1.
  - When starve_cnt == STARVE_MAX, the next arbitration grants the loader even if cpu_req=1.
  - The counter clears on a loader grant, or at any IDLE-state edge where ld_req=0.
- Not defined: strict CPU priority. The loader may starve indefinitely. No counter logic is present.

Decomposition:
- Shared package coderam_pkg holds:
  - address/data width constants (AW=13, DW=8)
  - FSM state encoding (IDLE=0, ACCESS=1, CAPTURE=2, ACK=3)
  - owner encoding (OWN_CPU=0, OWN_LD=1)
- One sub-module is natural: coderam_arb_pick, a combinational grant selector containing the priority logic and the starve counter compare. Its inputs are cpu_req, ld_req and starve_cnt; its output is the winner.
- FSM and datapath registers stay in the top module.

Test Plan:
- CPU read only: preload RAM[0x0123]=0x5A; cpu_req=1, we=0, addr=0x0123 at edge 0 → ram_cs_n low for exactly one cycle; cpu_ack high in the cycle after edge 2 with cpu_rdata=0x5A; ld_ack stays 0.
- Loader write then CPU read: ld write 0x1FFF←0xA5, then CPU read 0x1FFF → ram_we_n low for one cycle, ld_ack once, cpu_rdata=0xA5. Covers the top-address boundary.
- Simultaneous: cpu_req and ld_req both rise at the same edge with different addresses → CPU served first, loader served next. Acks are 4 cycles apart and never overlap.
- Starvation (CODERAM_ARB_FAIRNESS_EN, STARVE_MAX=4): cpu_req held continuously with back-to-back reads, ld_req held → the loader is granted on the 5th arbitration. Without the macro, ld_ack never fires within 40 cycles.
- Reset mid-write: assert reset_n=0 during ACCESS of a CPU write to 0x0010 (old value 0x00) → no ack; ram_cs_n=1 and ram_we_n=1 immediately; a later read of 0x0010 returns 0x00.
- Held req: cpu_req kept high through ACK → exactly one ack per transaction, a new transaction starts from IDLE, and busy drops for the IDLE cycle.
